change_dispenser: RTL and testbench

//  Drives the coin-return mechanism: the transmit side of the coin interface whose receive side the vending machine

---
 rtl/change_dispenser_pkg.sv | 19 +
 rtl/change_dispenser_pick.sv | 19 +
 rtl/change_dispenser.sv | 87 ++++++++
 tb/tb_change_dispenser.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg: coin codes, nickel values and FSM states shared by the coin dispenser
package change_dispenser_pkg;
  localparam logic [2:0] COIN_NONE    = 3'd0;
  localparam logic [2:0] COIN_NICKEL  = 3'd1;
  localparam logic [2:0] COIN_DIME    = 3'd2;
  localparam logic [2:0] COIN_QUARTER = 3'd3;
  localparam logic [2:0] COIN_FIFTY   = 3'd4;
  localparam logic [2:0] COIN_DOLLAR  = 3'd5;
  localparam logic [2:0] COIN_FIVE    = 3'd6;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_DONE} state_t;
  function automatic logic [6:0] coin_value(input logic [2:0] code);
    return code == COIN_FIVE    ? 7'd100 :
           code == COIN_DOLLAR  ? 7'd20  :
           code == COIN_FIFTY   ? 7'd10  :
           code == COIN_QUARTER ? 7'd5   :
           code == COIN_DIME    ? 7'd2   :
           code == COIN_NICKEL  ? 7'd1   : 7'd0;
  endfunction
endpackage

// File: rtl/change_dispenser_pick.sv
// change_dispenser_pick: greedy choice of the largest coin not exceeding the amount still owed
module change_dispenser_pick
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic [AMT_W-1:0] i_rem,
  output logic [2:0]       o_code
);
  logic [31:0] w_rem;
  assign w_rem = 32'(i_rem);
  always_comb
    o_code = w_rem >= 32'd100 ? COIN_FIVE    :
             w_rem >= 32'd20  ? COIN_DOLLAR  :
             w_rem >= 32'd10  ? COIN_FIFTY   :
             w_rem >= 32'd5   ? COIN_QUARTER :
             w_rem >= 32'd2   ? COIN_DIME    :
             w_rem >= 32'd1   ? COIN_NICKEL  : COIN_NONE;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: issues owed change one coin at a time, largest first, over a valid/ready handshake
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W      = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [AMT_W-1:0] i_amount,
  output logic             o_coin_valid,
  output logic [2:0]       o_coin_sel,
  input  logic             i_coin_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [AMT_W-1:0] o_remaining,
  output logic [7:0]       o_coins_issued
);
  state_t           r_state;
  logic             r_valid, r_busy, r_done;
  logic [2:0]       r_sel;
  logic [AMT_W-1:0] r_rem;
  logic [7:0]       r_cnt, r_gap;
  logic [AMT_W-1:0] w_pick_in;
  logic [2:0]       w_pick;
  assign w_pick_in = (r_state == S_IDLE) ? i_amount : r_rem;
  change_dispenser_pick #(.AMT_W(AMT_W)) u_pick (.i_rem(w_pick_in), .o_code(w_pick));
  // gap counter runs from GAP_CYCLES down to 0, so a coin-to-coin period is GAP_CYCLES+2
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_sel   <= COIN_NONE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_rem  <= i_amount;
          r_cnt  <= '0;
          r_busy <= 1'b1;
          if (i_amount == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_ISSUE;
            r_valid <= 1'b1;
            r_sel   <= w_pick;
          end
        end
        S_ISSUE: if (i_coin_ready) begin
          r_rem   <= r_rem - AMT_W'(coin_value(r_sel));
          r_cnt   <= (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
          r_valid <= 1'b0;
          r_sel   <= COIN_NONE;
          r_gap   <= 8'(GAP_CYCLES);
          r_state <= S_GAP;
        end
        S_GAP: if (r_gap != '0) r_gap <= r_gap - 8'd1;
          else if (r_rem == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_ISSUE;
            r_valid <= 1'b1;
            r_sel   <= w_pick;
          end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign o_coin_valid   = r_valid;
  assign o_coin_sel     = r_sel;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_remaining    = r_rem;
  assign o_coins_issued = r_cnt;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table-driven change sequences plus stall, busy-start and mid-run reset cases
module tb_change_dispenser;
  localparam int GAP = 4;
  typedef struct packed {
    logic [7:0]      amt;
    logic [3:0]      n;
    logic [7:0][2:0] seq;
  } vec_t;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b0;
  logic [7:0] amount = 8'd0;
  logic       valid, busy, done;
  logic [2:0] sel;
  logic [7:0] rem, issued;
  int         errors = 0, checks = 0;
  vec_t       vecs [7];
  always #5 clk = ~clk;
  change_dispenser #(.AMT_W(8), .GAP_CYCLES(GAP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_amount(amount),
    .o_coin_valid(valid), .o_coin_sel(sel), .i_coin_ready(ready),
    .o_busy(busy), .o_done(done), .o_remaining(rem), .o_coins_issued(issued)
  );
  function automatic logic [7:0] cv(input logic [2:0] c);
    case (c)
      3'd1: return 8'd1;
      3'd2: return 8'd2;
      3'd3: return 8'd5;
      3'd4: return 8'd10;
      3'd5: return 8'd20;
      3'd6: return 8'd100;
      default: return 8'd0;
    endcase
  endfunction
  function automatic vec_t mk(input logic [7:0] a, input logic [3:0] n,
                              input logic [2:0] s0, s1, s2, s3, s4, s5);
    vec_t v;
    v = '0;
    v.amt = a; v.n = n;
    v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2;
    v.seq[3] = s3; v.seq[4] = s4; v.seq[5] = s5;
    return v;
  endfunction
  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", tag, name, act, exp);
    end
  endtask
  task automatic pulse_start(input logic [7:0] a);
    @(negedge clk);
    amount = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic collect(input logic [7:0] a, input int n, input logic [7:0][2:0] seq, input string tag);
    int k = 0, last = -1, nd = 0;
    logic [7:0] er = a;
    for (int c = 0; c < 400 && nd == 0; c++) begin
      if (valid) begin
        if (k < n) begin
          chk(tag, "coin", 32'(sel), 32'(seq[k]));
          chk(tag, "remaining", 32'(rem), 32'(er));
          er = er - cv(seq[k]);
        end
        if (last >= 0) chk(tag, "spacing", c - last, GAP + 2);
        last = c;
        k++;
      end
      if (done) nd++;
      if (nd == 0) begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    chk(tag, "done_seen", nd, 1);
    chk(tag, "coin_count", k, n);
    chk(tag, "coins_issued", 32'(issued), n);
    chk(tag, "final_remaining", 32'(rem), 0);
    chk(tag, "busy_in_done", 32'(busy), 1);
    @(negedge clk);
    chk(tag, "done_one_cycle", 32'(done), 0);
    chk(tag, "idle_not_busy", 32'(busy), 0);
  endtask
  initial begin
    int bad;
    vecs[0] = mk(8'd0,   4'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    vecs[1] = mk(8'd19,  4'd4, 3'd4, 3'd3, 3'd2, 3'd2, 3'd0, 3'd0);
    vecs[2] = mk(8'd125, 4'd3, 3'd6, 3'd5, 3'd3, 3'd0, 3'd0, 3'd0);
    vecs[3] = mk(8'd1,   4'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    vecs[4] = mk(8'd255, 4'd6, 3'd6, 3'd6, 3'd5, 3'd5, 3'd4, 3'd3);
    vecs[5] = mk(8'd40,  4'd2, 3'd5, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0);
    vecs[6] = mk(8'd30,  4'd2, 3'd5, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0);
    repeat (3) @(negedge clk);
    chk("reset", "valid", 32'(valid), 0);
    chk("reset", "sel", 32'(sel), 0);
    chk("reset", "busy", 32'(busy), 0);
    chk("reset", "done", 32'(done), 0);
    chk("reset", "remaining", 32'(rem), 0);
    chk("reset", "issued", 32'(issued), 0);
    rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pulse_start(vecs[i].amt);
      collect(vecs[i].amt, int'(vecs[i].n), vecs[i].seq, $sformatf("vec%0d_amt%0d", i, vecs[i].amt));
    end
    // hopper stall: the dime must stay presented unchanged
    ready = 1'b0;
    pulse_start(8'd3);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (!(valid === 1'b1 && sel === 3'd2 && rem === 8'd3)) bad++;
      @(negedge clk);
    end
    chk("stall", "unstable_cycles", bad, 0);
    ready = 1'b1;
    collect(8'd3, 2, {18'd0, 3'd1, 3'd2}, "stall");
    // second start while busy is dropped
    pulse_start(8'd7);
    amount = 8'd40;
    start = 1'b1;
    collect(8'd7, 2, {18'd0, 3'd2, 3'd3}, "busy_start");
    // reset during the gap after the first coin
    pulse_start(8'd100);
    chk("midreset", "first_coin", 32'(sel), 6);
    @(negedge clk);
    chk("midreset", "in_gap_issued", 32'(issued), 1);
    rst_n = 1'b0;
    #1;
    chk("midreset", "valid", 32'(valid), 0);
    chk("midreset", "busy", 32'(busy), 0);
    chk("midreset", "remaining", 32'(rem), 0);
    chk("midreset", "issued", 32'(issued), 0);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || valid !== 1'b0) bad++;
    end
    chk("midreset", "no_done", bad, 0);
    rst_n = 1'b1;
    pulse_start(8'd19);
    collect(8'd19, 4, {12'd0, 3'd2, 3'd2, 3'd3, 3'd4}, "after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
